// File: rtl/maze_solve_if.sv
// ---------------------------------------------------------------------------
// maze_solve_if
//   Signal bundle between the wall-following solver and the host/motion side.
//
//   Host -> solver : cmd_md (1 = command mode), cmd0 (wall affinity, 1 = left),
//                    lft_opn / rght_opn / frwrd_opn (maze sensing),
//                    mv_cmplt (heading or move finished), sol_cmplt (exit found)
//   Solver -> host : strt_hdng (pulse), dsrd_hdng[11:0], strt_mv (pulse),
//                    stp_lft / stp_rght (stop-at-opening selects)
//
//   master : the host / motion controller side
//   slave  : the solver (maze_solve)
// ---------------------------------------------------------------------------
interface maze_solve_if;
  logic        cmd_md;
  logic        cmd0;
  logic        lft_opn;
  logic        rght_opn;
  logic        frwrd_opn;
  logic        mv_cmplt;
  logic        sol_cmplt;
  logic        strt_hdng;
  logic [11:0] dsrd_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;

  modport master (
    output cmd_md, cmd0, lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt,
    input  strt_hdng, dsrd_hdng, strt_mv, stp_lft, stp_rght
  );

  modport slave (
    input  cmd_md, cmd0, lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt,
    output strt_hdng, dsrd_hdng, strt_mv, stp_lft, stp_rght
  );
endinterface

// File: rtl/maze_solve.sv
// ---------------------------------------------------------------------------
// maze_solve
//   Wall-following maze solver. A falling edge on cmd_md starts a solve with
//   the affinity sampled from cmd0. The solver alternates forward moves and
//   heading changes, choosing each turn from the opening sensors once the
//   previous move completes, until sol_cmplt (exit) or cmd_md (abort).
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : maze_solve_if.slave (see interface header for signal list)
//
//   All outputs are registered. Heading codes: N=000, W=3FF, S=7FF, E=C00.
// ---------------------------------------------------------------------------
module maze_solve (
  input  logic         clk,
  input  logic         rst_n,
  maze_solve_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE      = 3'd1,
    WAIT_MV   = 3'd2,
    DECIDE    = 3'd3,
    TURN      = 3'd4,
    WAIT_HDNG = 3'd5
  } state_t;

  // Map the 2-bit direction index to the 12-bit heading code.
  function automatic logic [11:0] hdng_code(input logic [1:0] dir);
    logic [11:0] code;
    case (dir)
      2'd0:    code = 12'h000;
      2'd1:    code = 12'h3FF;
      2'd2:    code = 12'h7FF;
      2'd3:    code = 12'hC00;
      default: code = 12'h000;
    endcase
    return code;
  endfunction

  // Direction increment chosen by the wall-follow rule.
  // +1 = left turn, +3 (== -1 mod 4) = right turn, +2 = about-face, 0 = straight.
  function automatic logic [1:0] turn_delta(input logic aff,
                                            input logic lft,
                                            input logic frwrd,
                                            input logic rght);
    logic [1:0] delta;
    if (aff) begin
      if (lft)        delta = 2'd1;
      else if (frwrd) delta = 2'd0;
      else if (rght)  delta = 2'd3;
      else            delta = 2'd2;
    end else begin
      if (rght)       delta = 2'd3;
      else if (frwrd) delta = 2'd0;
      else if (lft)   delta = 2'd1;
      else            delta = 2'd2;
    end
    return delta;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  dir_r;
  logic [1:0]  dir_nxt_s;
  logic        aff_r;
  logic        aff_nxt_s;
  logic        cmd_md_q;
  logic        strt_mv_r;
  logic        strt_mv_nxt_s;
  logic        strt_hdng_r;
  logic        strt_hdng_nxt_s;
  logic        stp_lft_r;
  logic        stp_lft_nxt_s;
  logic        stp_rght_r;
  logic        stp_rght_nxt_s;
  logic [11:0] dsrd_hdng_r;
  logic        start_s;
  logic        abort_s;
  logic [1:0]  delta_s;

  // Start is the falling edge of cmd_md, so holding solve mode never restarts.
  assign start_s = cmd_md_q & ~bus.cmd_md;

  // Exit found or command mode re-entered: leave any busy state at once.
  assign abort_s = (state_r != IDLE) & (bus.sol_cmplt | bus.cmd_md);

  assign delta_s = turn_delta(aff_r, bus.lft_opn, bus.frwrd_opn, bus.rght_opn);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dir_r       <= 2'd0;
      aff_r       <= 1'b0;
      cmd_md_q    <= 1'b1;
      strt_mv_r   <= 1'b0;
      strt_hdng_r <= 1'b0;
      stp_lft_r   <= 1'b0;
      stp_rght_r  <= 1'b0;
      dsrd_hdng_r <= 12'h000;
    end else begin
      state_r     <= state_nxt_s;
      dir_r       <= dir_nxt_s;
      aff_r       <= aff_nxt_s;
      cmd_md_q    <= bus.cmd_md;
      strt_mv_r   <= strt_mv_nxt_s;
      strt_hdng_r <= strt_hdng_nxt_s;
      stp_lft_r   <= stp_lft_nxt_s;
      stp_rght_r  <= stp_rght_nxt_s;
      // Heading tracks dir at the same edge so it is stable before strt_hdng.
      dsrd_hdng_r <= hdng_code(dir_nxt_s);
    end
  end

  // Next-state, direction update and strobe generation.
  always_comb begin
    state_nxt_s     = state_r;
    dir_nxt_s       = dir_r;
    aff_nxt_s       = aff_r;
    stp_lft_nxt_s   = stp_lft_r;
    stp_rght_nxt_s  = stp_rght_r;
    strt_mv_nxt_s   = 1'b0;
    strt_hdng_nxt_s = 1'b0;

    if (abort_s) begin
      // Abort wins over everything, including a coincident mv_cmplt.
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            aff_nxt_s      = bus.cmd0;
            stp_lft_nxt_s  = bus.cmd0;
            stp_rght_nxt_s = ~bus.cmd0;
            state_nxt_s    = MOVE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MOVE: begin
          strt_mv_nxt_s = 1'b1;
          state_nxt_s   = WAIT_MV;
        end
        WAIT_MV: begin
          if (bus.mv_cmplt) begin
            state_nxt_s = DECIDE;
          end else begin
            state_nxt_s = WAIT_MV;
          end
        end
        DECIDE: begin
          if (delta_s == 2'd0) begin
            state_nxt_s = MOVE;
          end else begin
            // Modulo-4 wrap comes for free from the 2-bit add.
            dir_nxt_s   = dir_r + delta_s;
            state_nxt_s = TURN;
          end
        end
        TURN: begin
          strt_hdng_nxt_s = 1'b1;
          state_nxt_s     = WAIT_HDNG;
        end
        WAIT_HDNG: begin
          if (bus.mv_cmplt) begin
            state_nxt_s = MOVE;
          end else begin
            state_nxt_s = WAIT_HDNG;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  assign bus.strt_mv   = strt_mv_r;
  assign bus.strt_hdng = strt_hdng_r;
  assign bus.stp_lft   = stp_lft_r;
  assign bus.stp_rght  = stp_rght_r;
  assign bus.dsrd_hdng = dsrd_hdng_r;

endmodule

// File: tb/tb_maze_solve.sv
// ---------------------------------------------------------------------------
// tb_maze_solve
//   Self-checking bench for maze_solve. Each scenario task pushes the strobe
//   it expects (kind, heading, cycle) onto exp_q; a negedge monitor pushes
//   every strobe the DUT produces onto obs_q; the task pops and compares.
// ---------------------------------------------------------------------------
module tb_maze_solve;

  typedef struct packed {
    logic        mv;
    logic        hd;
    logic [11:0] hdng;
    logic [31:0] cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  maze_solve_if bus ();

  maze_solve dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the heading present at that moment.
  always @(negedge clk) begin
    if (rst_n && (bus.strt_mv || bus.strt_hdng))
      obs_q.push_back({bus.strt_mv, bus.strt_hdng, bus.dsrd_hdng, cyc});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mv(output int c);
    step();
    bus.mv_cmplt = 1'b1;
    c = cyc;
    step();
    bus.mv_cmplt = 1'b0;
  endtask

  task automatic wait_obs(input int budget, output bit got);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = (obs_q.size() > 0);
  endtask

  task automatic set_opn(input logic [2:0] lfr);
    bus.lft_opn   = lfr[2];
    bus.frwrd_opn = lfr[1];
    bus.rght_opn  = lfr[0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_md = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.strt_mv, bus.strt_hdng, bus.stp_lft, bus.stp_rght} !== 4'b0000)
      $display("FAIL reset_flags: got mv=%b hd=%b sl=%b sr=%b, required all 0",
               bus.strt_mv, bus.strt_hdng, bus.stp_lft, bus.stp_rght);
    else pass_cnt++;
    total_cnt++;
    if (bus.dsrd_hdng !== 12'h000)
      $display("FAIL reset_hdng: got %h, required 000", bus.dsrd_hdng);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    total_cnt++;
    if (obs_q.size() !== 0)
      $display("FAIL reset_quiet: got %0d strobes, required 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_start();
    ev_t e, o;
    bit  got;
    int  c;
    step();
    bus.cmd0 = 1'b1;
    bus.cmd_md = 1'b0;
    c = cyc;
    exp_q.push_back({1'b1, 1'b0, 12'h000, c + 2});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL start_mv: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL start_mv: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
    total_cnt++;
    if ({bus.stp_lft, bus.stp_rght} !== 2'b10)
      $display("FAIL start_stp: got sl=%b sr=%b, required sl=1 sr=0", bus.stp_lft, bus.stp_rght);
    else pass_cnt++;
  endtask

  task automatic test_left_turn();
    ev_t e, o;
    bit  got;
    int  c;
    set_opn(3'b111);
    pulse_mv(c);
    exp_q.push_back({1'b0, 1'b1, 12'h3FF, c + 3});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL left_hdng: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL left_hdng: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
    pulse_mv(c);
    exp_q.push_back({1'b1, 1'b0, 12'h3FF, c + 2});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL left_mv: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL left_mv: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
  endtask

  task automatic test_forward();
    ev_t e, o;
    bit  got;
    int  c;
    set_opn(3'b011);
    pulse_mv(c);
    exp_q.push_back({1'b1, 1'b0, 12'h3FF, c + 3});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL forward_mv: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL forward_mv: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
  endtask

  task automatic test_sol_cmplt();
    set_opn(3'b100);
    step();
    bus.sol_cmplt = 1'b1;
    bus.mv_cmplt  = 1'b1;
    step();
    bus.sol_cmplt = 1'b0;
    bus.mv_cmplt  = 1'b0;
    repeat (8) step();
    total_cnt++;
    if (obs_q.size() !== 0)
      $display("FAIL sol_quiet: got %0d strobes, required 0", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if ({bus.dsrd_hdng, bus.stp_lft, bus.stp_rght} !== {12'h3FF, 2'b10})
      $display("FAIL sol_retain: got hdng=%h sl=%b sr=%b, required hdng=3ff sl=1 sr=0",
               bus.dsrd_hdng, bus.stp_lft, bus.stp_rght);
    else pass_cnt++;
  endtask

  task automatic test_abort_hdng();
    ev_t e, o;
    bit  got;
    int  c;
    step();
    bus.cmd_md = 1'b1;
    step();
    bus.cmd_md = 1'b0;
    c = cyc;
    exp_q.push_back({1'b1, 1'b0, 12'h3FF, c + 2});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL restart_mv: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL restart_mv: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
    set_opn(3'b100);
    pulse_mv(c);
    exp_q.push_back({1'b0, 1'b1, 12'h7FF, c + 3});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL abort_hdng_turn: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL abort_hdng_turn: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
    step();
    bus.cmd_md = 1'b1;
    step();
    pulse_mv(c);
    repeat (6) step();
    total_cnt++;
    if (obs_q.size() !== 0)
      $display("FAIL abort_quiet: got %0d strobes, required 0", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (bus.dsrd_hdng !== 12'h7FF)
      $display("FAIL abort_retain: got %h, required 7ff", bus.dsrd_hdng);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_solve();
    ev_t e, o;
    bit  got;
    int  c;
    step();
    bus.cmd_md = 1'b0;
    c = cyc;
    exp_q.push_back({1'b1, 1'b0, 12'h7FF, c + 2});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL midrst_mv: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e)
        $display("FAIL midrst_mv: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                 o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
      else pass_cnt++;
    end
    // strt_mv is high right now; an asynchronous reset must clear it mid-cycle.
    rst_n = 1'b0;
    bus.cmd_md = 1'b1;
    #1;
    total_cnt++;
    if ({bus.strt_mv, bus.stp_lft, bus.stp_rght, bus.dsrd_hdng} !== {3'b000, 12'h000})
      $display("FAIL midrst_clear: got mv=%b sl=%b sr=%b hdng=%h, required 0 0 0 000",
               bus.strt_mv, bus.stp_lft, bus.stp_rght, bus.dsrd_hdng);
    else pass_cnt++;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    total_cnt++;
    if (obs_q.size() !== 0)
      $display("FAIL midrst_quiet: got %0d strobes, required 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_right_affinity();
    ev_t         e, o;
    bit          got;
    int          c;
    logic [2:0]  opn_tab [4];
    logic [11:0] hd_tab  [4];
    opn_tab = '{3'b000, 3'b001, 3'b000, 3'b100};
    hd_tab  = '{12'h7FF, 12'h3FF, 12'hC00, 12'h000};
    step();
    bus.cmd0 = 1'b0;
    bus.cmd_md = 1'b0;
    c = cyc;
    exp_q.push_back({1'b1, 1'b0, 12'h000, c + 2});
    wait_obs(10, got);
    total_cnt++;
    e = exp_q.pop_front();
    if (!got) $display("FAIL right_start: no strobe, required cyc=%0d", e.cyc);
    else begin
      o = obs_q.pop_front();
      if (o !== e || {bus.stp_lft, bus.stp_rght} !== 2'b01)
        $display("FAIL right_start: got mv=%b hdng=%h cyc=%0d sl=%b sr=%b, required mv=1 hdng=000 cyc=%0d sl=0 sr=1",
                 o.mv, o.hdng, o.cyc, bus.stp_lft, bus.stp_rght, e.cyc);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      set_opn(opn_tab[i]);
      pulse_mv(c);
      exp_q.push_back({1'b0, 1'b1, hd_tab[i], c + 3});
      wait_obs(10, got);
      total_cnt++;
      e = exp_q.pop_front();
      if (!got) $display("FAIL right_turn[%0d]: no strobe, required hdng=%h", i, e.hdng);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("FAIL right_turn[%0d]: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                   i, o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
        else pass_cnt++;
      end
      pulse_mv(c);
      exp_q.push_back({1'b1, 1'b0, hd_tab[i], c + 2});
      wait_obs(10, got);
      total_cnt++;
      e = exp_q.pop_front();
      if (!got) $display("FAIL right_mv[%0d]: no strobe, required cyc=%0d", i, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("FAIL right_mv[%0d]: got mv=%b hd=%b hdng=%h cyc=%0d, required mv=%b hd=%b hdng=%h cyc=%0d",
                   i, o.mv, o.hd, o.hdng, o.cyc, e.mv, e.hd, e.hdng, e.cyc);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    cyc           = 0;
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    bus.cmd_md    = 1'b1;
    bus.cmd0      = 1'b0;
    bus.lft_opn   = 1'b0;
    bus.rght_opn  = 1'b0;
    bus.frwrd_opn = 1'b0;
    bus.mv_cmplt  = 1'b0;
    bus.sol_cmplt = 1'b0;
    test_reset();
    test_start();
    test_left_turn();
    test_forward();
    test_sol_cmplt();
    test_abort_hdng();
    test_reset_mid_solve();
    test_right_affinity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

endmodule

// File: doc/maze_solve.md
MAZE_SOLVE -- requirements
Module: maze_solve

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port cmd_md  input  1  1 = command mode (solver dormant); 0 = solve mode.
REQ-004 SHALL have port cmd0  input  1  wall-follow affinity, sampled at start: 1 = left, 0 = right.
REQ-005 SHALL have port lft_opn  input  1  opening to the robot's left.
REQ-006 SHALL have port rght_opn  input  1  opening to the robot's right.
REQ-007 SHALL have port frwrd_opn  input  1  path ahead open.
REQ-008 SHALL have port mv_cmplt  input  1  single-cycle pulse; heading or move done.
REQ-009 SHALL have port sol_cmplt  input  1  maze exit found.
REQ-010 SHALL have port strt_hdng  output  1  single-cycle pulse; start heading change to dsrd_hdng.
REQ-011 SHALL have port dsrd_hdng  output  12  desired heading, registered.
REQ-012 SHALL have port strt_mv  output  1  single-cycle pulse; start forward move.
REQ-013 SHALL have port stp_lft  output  1  stop move at left opening, registered.
REQ-014 SHALL have port stp_rght  output  1  stop move at right opening, registered.

Function
REQ-015 SHALL hold a 2-bit direction index dir: 0 = N (12'h000), 1 = W (12'h3FF), 2 = S (12'h7FF), 3 = E (12'hC00); dsrd_hdng SHALL always equal the code of dir.
REQ-016 SHALL implement states IDLE, MOVE, WAIT_MV, DECIDE, TURN, WAIT_HDNG.
REQ-017 SHALL register cmd_md each cycle (cmd_md_q, reset 1); start condition = cmd_md_q==1 && cmd_md==0 (falling edge), not level.
REQ-018 IDLE: on start, latch aff = cmd0, set stp_lft = aff, stp_rght = ~aff, go MOVE; otherwise stay.
REQ-019 MOVE: assert strt_mv for exactly one cycle, go WAIT_MV.
REQ-020 WAIT_MV: hold until mv_cmplt, then go DECIDE.
REQ-021 DECIDE (one cycle), left affinity: lft_opn -> dir+1; else frwrd_opn -> no turn; else rght_opn -> dir-1; else dir+2.
REQ-022 DECIDE, right affinity: rght_opn -> dir-1; else frwrd_opn -> no turn; else lft_opn -> dir+1; else dir+2.
REQ-023 Direction arithmetic SHALL be modulo 4 (N-1 = E, E+1 = N, S+2 = N).
REQ-024 DECIDE with no turn SHALL go MOVE; with turn SHALL update dir/dsrd_hdng at the same edge and go TURN.
REQ-025 TURN: assert strt_hdng for one cycle with the updated dsrd_hdng already stable, go WAIT_HDNG.
REQ-026 WAIT_HDNG: hold until mv_cmplt, then go MOVE.
REQ-027 sol_cmplt in any non-IDLE state SHALL force IDLE on the next edge, no strobe in that cycle; sol_cmplt has priority over mv_cmplt.
REQ-028 cmd_md==1 in any non-IDLE state SHALL abort to IDLE on the next edge, strobes suppressed.
REQ-029 dir, dsrd_hdng and stp_lft/stp_rght SHALL retain their values on return to IDLE; the next solve continues from the last heading.
REQ-030 mv_cmplt outside WAIT_MV/WAIT_HDNG SHALL be ignored; a second start while busy SHALL be ignored.
REQ-031 strt_mv and strt_hdng SHALL never assert in the same cycle.

Reset
REQ-032 Async reset SHALL give: state IDLE, dir 0, dsrd_hdng 12'h000, strt_mv 0, strt_hdng 0, stp_lft 0, stp_rght 0, cmd_md_q 1.
REQ-033 Reset asserted mid-solve SHALL clear immediately; after release no strobe until a new cmd_md falling edge.

Verification
REQ-034 Reset, cmd0=1, cmd_md 1->0 -> strt_mv pulse 2 cycles after the edge; stp_lft=1, stp_rght=0.
REQ-035 Left affinity, mv_cmplt with lft_opn=1 -> dsrd_hdng 12'h3FF, one strt_hdng; mv_cmplt -> strt_mv.
REQ-036 Right affinity from N, dead end (all opn=0) -> dsrd_hdng 12'h7FF; then right turn with rght_opn=1 -> 12'h3FF (wrap S-1=W).
REQ-037 Left affinity, lft_opn=0, frwrd_opn=1 at mv_cmplt -> no strt_hdng, strt_mv within 2 cycles, dsrd_hdng unchanged.
REQ-038 sol_cmplt and mv_cmplt together in WAIT_MV -> IDLE, no strobe; cmd_md held 0 -> no restart.
REQ-039 cmd_md raised in WAIT_HDNG -> IDLE next cycle; later mv_cmplt ignored; dsrd_hdng retained.
